ej32_mem_arb: RTL and testbench

Single-port memory arbiter for the eJ32 core. It shares the byte-wide synchronous memory bus between three requesters: instruction fetch (IF), the load/store unit (LS, multi-byte iaload/iastore/ldi bursts) and an optional host/debug port (HS). It sits between the decoder/LS datapath and the memory macro. It returns a `stall` to the decoder so that phase sequencing holds while fetch is starved.

---
 rtl/ej32_mem_arb.sv | 138 +++++++++++++
 tb/tb_ej32_mem_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ej32_mem_arb.sv
// eJ32 single-port byte memory arbiter: IF / LS (lockable bursts) / optional host port.
// Define EJ32_HOST_PORT_EN to build the host port with its starvation-forced grant.
module ej32_mem_arb #(
    parameter int ASZ      = 17,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [ASZ-1:0] if_addr,
    output logic           if_gnt,
    output logic           if_vld,
    input  logic           ls_req,
    input  logic           ls_we,
    input  logic           ls_lock,
    input  logic [ASZ-1:0] ls_addr,
    input  logic [7:0]     ls_wdata,
    output logic           ls_gnt,
    output logic           ls_vld,
    input  logic           hs_req,
    input  logic           hs_we,
    input  logic [ASZ-1:0] hs_addr,
    input  logic [7:0]     hs_wdata,
    output logic           hs_gnt,
    output logic           hs_vld,
    output logic [ASZ-1:0] mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata,
    output logic [7:0]     rdata,
    output logic           stall
);

`ifdef EJ32_HOST_PORT_EN
    typedef enum logic [1:0] {IDLE, LSL, HSF} own_t;
    localparam logic [3:0] MAXW = 4'(MAX_WAIT);
    logic [3:0] hwait_q, hwait_d;
    logic       hs_vld_q;
`else
    typedef enum logic [1:0] {IDLE, LSL} own_t;
    logic unused_hs;
    assign unused_hs = ^{hs_req, hs_we, hs_addr, hs_wdata};
`endif

    own_t       own_q, own_d;
    logic       gnt_if, gnt_ls, gnt_hs;
    logic       if_vld_q, ls_vld_q;
    logic [7:0] rdata_q;

    // Grants are forced low while reset is asserted.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        gnt_hs = 1'b0;
        if (rst) begin
`ifdef EJ32_HOST_PORT_EN
            if (own_q == HSF && hs_req) gnt_hs = 1'b1;
            else
`endif
            if (own_q == LSL)  gnt_ls = ls_req;
            else if (ls_req)   gnt_ls = 1'b1;
            else if (if_req)   gnt_if = 1'b1;
`ifdef EJ32_HOST_PORT_EN
            else if (hs_req)   gnt_hs = 1'b1;
`endif
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt_ls) begin
            mem_addr  = ls_addr;
            mem_we    = ls_we;
            mem_wdata = ls_wdata;
        end else if (gnt_if) begin
            mem_addr  = if_addr;
`ifdef EJ32_HOST_PORT_EN
        end else if (gnt_hs) begin
            mem_addr  = hs_addr;
            mem_we    = hs_we;
            mem_wdata = hs_wdata;
`endif
        end
    end

    always_comb begin
        own_d = own_q;
        if (gnt_ls)             own_d = ls_lock ? LSL : IDLE;
        else if (own_q != LSL)  own_d = IDLE;
`ifdef EJ32_HOST_PORT_EN
        hwait_d = hwait_q;
        if (!hs_req || gnt_hs)  hwait_d = '0;
        else if (hwait_q < MAXW) hwait_d = hwait_q + 4'd1;
        // A starved host waits out a locked burst, then wins the next cycle.
        if (hwait_d == MAXW && own_d != LSL) own_d = HSF;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q    <= IDLE;
            if_vld_q <= 1'b0;
            ls_vld_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            own_q    <= own_d;
            if_vld_q <= gnt_if;
            ls_vld_q <= gnt_ls & ~ls_we;
            rdata_q  <= mem_rdata;
        end
    end

`ifdef EJ32_HOST_PORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwait_q  <= '0;
            hs_vld_q <= 1'b0;
        end else begin
            hwait_q  <= hwait_d;
            hs_vld_q <= gnt_hs & ~hs_we;
        end
    end
    assign hs_vld = hs_vld_q;
`else
    assign hs_vld = 1'b0;
`endif

    assign if_gnt = gnt_if;
    assign ls_gnt = gnt_ls;
    assign hs_gnt = gnt_hs;
    assign if_vld = if_vld_q;
    assign ls_vld = ls_vld_q;
    assign rdata  = rdata_q;
    assign stall  = rst & if_req & ~gnt_if;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Scoreboard bench for ej32_mem_arb: directed scenarios followed by random traffic,
// checked against a cycle-level ownership model and a reference byte memory.
module tb_ej32_mem_arb;
    localparam int ASZ = 17;
    localparam int MW  = 4;
`ifdef EJ32_HOST_PORT_EN
    localparam bit HOST = 1'b1;
`else
    localparam bit HOST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_req, ls_req, ls_we, ls_lock, hs_req, hs_we;
    logic [ASZ-1:0] if_addr, ls_addr, hs_addr, mem_addr;
    logic [7:0] ls_wdata, hs_wdata, mem_wdata, mem_rdata, rdata;
    logic if_gnt, if_vld, ls_gnt, ls_vld, hs_gnt, hs_vld, mem_we, stall;

    ej32_mem_arb #(.ASZ(ASZ), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_vld(if_vld),
        .ls_req(ls_req), .ls_we(ls_we), .ls_lock(ls_lock), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_vld(ls_vld),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_gnt(hs_gnt), .hs_vld(hs_vld),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return (a == 16) ? 8'hB6 : 8'(a * 37 + 5);
    endfunction

    // Memory macro: combinational read of the presented address, write on the edge.
    logic [7:0] mem_arr [0:1023];
    bit         mem_wr  [0:1023];
    assign mem_rdata = mem_wr[mem_addr[9:0]] ? mem_arr[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
    always @(posedge clk)
        if (mem_we) begin
            mem_arr[mem_addr[9:0]] <= mem_wdata;
            mem_wr[mem_addr[9:0]]  <= 1'b1;
        end

    typedef struct packed {
        logic           rst, if_req;
        logic [ASZ-1:0] if_addr;
        logic           ls_req, ls_we, ls_lock;
        logic [ASZ-1:0] ls_addr;
        logic [7:0]     ls_wdata;
        logic           hs_req, hs_we;
        logic [ASZ-1:0] hs_addr;
        logic [7:0]     hs_wdata;
    } rq_t;
    typedef struct {
        int cyc; bit rst; logic [2:0] gnt; logic stall, we;
        logic [ASZ-1:0] addr; logic [7:0] wd;
    } exp_t;
    typedef struct { int due; logic [2:0] who; logic [7:0] data; } rd_t;

    exp_t expq[$];
    rd_t  rdq[$];
    logic [7:0] ref_mem [int];
    int errors = 0, checks = 0, cyc = 0;
    bit m_locked = 0, m_forced = 0;
    int m_hwait = 0, last_win = 0;

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // One bus cycle: apply the request set, then let the model say what must happen.
    task automatic drive(input rq_t r);
        exp_t e; rd_t d; int w; int a;
        @(posedge clk); #1;
        rst = r.rst; if_req = r.if_req; if_addr = r.if_addr;
        ls_req = r.ls_req; ls_we = r.ls_we; ls_lock = r.ls_lock;
        ls_addr = r.ls_addr; ls_wdata = r.ls_wdata;
        hs_req = r.hs_req; hs_we = r.hs_we; hs_addr = r.hs_addr; hs_wdata = r.hs_wdata;
        e.cyc = cyc; e.rst = r.rst; e.gnt = 3'b000; e.stall = 1'b0;
        e.we = 1'b0; e.addr = '0; e.wd = '0;
        w = 0;
        if (!r.rst) begin
            m_locked = 0; m_forced = 0; m_hwait = 0;
            rdq.delete();
        end else begin
            if (m_forced && r.hs_req)    w = 3;
            else if (m_locked)           w = r.ls_req ? 2 : 0;
            else if (r.ls_req)           w = 2;
            else if (r.if_req)           w = 1;
            else if (HOST && r.hs_req)   w = 3;
            d.due = cyc + 1;
            if (w == 1) begin
                e.gnt = 3'b100; e.addr = r.if_addr;
                d.who = 3'b100; d.data = ref_rd(int'(r.if_addr[9:0])); rdq.push_back(d);
            end else if (w == 2) begin
                e.gnt = 3'b010; e.addr = r.ls_addr; e.we = r.ls_we; e.wd = r.ls_wdata;
                a = int'(r.ls_addr[9:0]);
                if (r.ls_we) ref_mem[a] = r.ls_wdata;
                else begin d.who = 3'b010; d.data = ref_rd(a); rdq.push_back(d); end
                m_locked = r.ls_lock;
            end else if (w == 3) begin
                e.gnt = 3'b001; e.addr = r.hs_addr; e.we = r.hs_we; e.wd = r.hs_wdata;
                a = int'(r.hs_addr[9:0]);
                if (r.hs_we) ref_mem[a] = r.hs_wdata;
                else begin d.who = 3'b001; d.data = ref_rd(a); rdq.push_back(d); end
            end
            e.stall = r.if_req && (w != 1);
            if (!r.hs_req || w == 3) m_hwait = 0;
            else if (m_hwait < MW)   m_hwait++;
            m_forced = HOST && (m_hwait == MW) && !m_locked;
        end
        expq.push_back(e);
        last_win = w;
        cyc++;
    endtask

    always @(negedge clk) begin : mon
        exp_t e; rd_t d; logic [2:0] gv, ev;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            checks++;
            if ({if_gnt, ls_gnt, hs_gnt, stall, mem_we, mem_addr} !== {e.gnt, e.stall, e.we, e.addr}) begin
                errors++;
                $display("FAIL bus cyc=%0d got gnt(if,ls,hs)=%b stall=%b we=%b addr=%h, need gnt=%b stall=%b we=%b addr=%h",
                         e.cyc, {if_gnt, ls_gnt, hs_gnt}, stall, mem_we, mem_addr, e.gnt, e.stall, e.we, e.addr);
            end
            if (e.we) begin
                checks++;
                if (mem_wdata !== e.wd) begin
                    errors++;
                    $display("FAIL wdata cyc=%0d got %h need %h", e.cyc, mem_wdata, e.wd);
                end
            end
            gv = {if_vld, ls_vld, hs_vld};
            if (!e.rst) begin
                checks++;
                if (gv !== 3'b000 || rdata !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_out cyc=%0d got vld=%b rdata=%h need 000/00", e.cyc, gv, rdata);
                end
            end else begin
                ev = 3'b000;
                if (rdq.size() != 0 && rdq[0].due == e.cyc) ev = rdq[0].who;
                checks++;
                if (gv !== ev) begin
                    errors++;
                    $display("FAIL vld cyc=%0d got (if,ls,hs)=%b need %b", e.cyc, gv, ev);
                end
                if (ev != 3'b000) begin
                    d = rdq.pop_front();
                    checks++;
                    if (rdata !== d.data) begin
                        errors++;
                        $display("FAIL rdata cyc=%0d got %h need %h", e.cyc, rdata, d.data);
                    end
                end
            end
        end
    end

    initial begin
        rq_t idle, r;
        bit p_if, p_ls, p_hs;
        #1 rst = 1'b0;
        idle = '0; idle.rst = 1'b1;
        r = '0;
        drive(r); drive(r);

        // IF read at 0x10 returns 0xB6 one cycle later.
        r = idle; r.if_req = 1'b1; r.if_addr = 17'h00010; drive(r);
        drive(idle);
        // IF and LS together: LS wins, IF stalls then gets the bus.
        r = idle; r.if_req = 1'b1; r.if_addr = 17'h00011;
        r.ls_req = 1'b1; r.ls_addr = 17'h00100; drive(r);
        r.ls_req = 1'b0; drive(r);
        // Four-byte locked burst with IF requesting throughout.
        for (int b = 0; b < 4; b++) begin
            r = idle; r.if_req = 1'b1; r.if_addr = 17'h00020;
            r.ls_req = 1'b1; r.ls_addr = 17'(32'h200 + b); r.ls_lock = (b < 3);
            drive(r);
        end
        r = idle; r.if_req = 1'b1; r.if_addr = 17'h00020; drive(r);
        // Locked burst with a bubble: nobody else gets in.
        r = idle; r.ls_req = 1'b1; r.ls_we = 1'b1; r.ls_lock = 1'b1;
        r.ls_addr = 17'h00210; r.ls_wdata = 8'hC3; r.if_req = 1'b1; r.if_addr = 17'h00210;
        drive(r);
        r.ls_req = 1'b0; drive(r);
        r.ls_req = 1'b1; r.ls_we = 1'b0; r.ls_lock = 1'b0; r.ls_addr = 17'h00210; drive(r);
        r.ls_req = 1'b0; drive(r);
        // Host write vs continuous LS and IF traffic.
        p_hs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = idle; r.if_req = 1'b1; r.if_addr = 17'h00030;
            r.ls_req = 1'b1; r.ls_addr = 17'(32'h40 + i);
            r.hs_req = p_hs; r.hs_we = 1'b1; r.hs_addr = 17'h00300; r.hs_wdata = 8'h55;
            drive(r);
            if (last_win == 3) p_hs = 1'b0;
        end
        r = idle; r.ls_req = 1'b1; r.ls_addr = 17'h00300; drive(r);
        // Host starved during a long locked burst.
        p_hs = 1'b1;
        for (int i = 0; i < 9; i++) begin
            r = idle; r.if_req = 1'b1; r.if_addr = 17'h00031;
            r.ls_req = (i < 7); r.ls_addr = 17'(32'h60 + i); r.ls_lock = (i < 6);
            r.hs_req = p_hs; r.hs_addr = 17'h00300;
            drive(r);
            if (last_win == 3) p_hs = 1'b0;
        end
        // Reset in the middle of a locked burst.
        for (int b = 0; b < 3; b++) begin
            r = idle; r.if_req = 1'b1; r.if_addr = 17'h00012;
            r.ls_req = 1'b1; r.ls_lock = 1'b1; r.ls_addr = 17'(32'h220 + b);
            r.rst = (b != 2);
            drive(r);
        end
        r = idle; r.if_req = 1'b1; r.if_addr = 17'h00012; drive(r);
        drive(idle);
        // Host request held high while IF/LS patterns repeat.
        for (int b = 0; b < 6; b++) begin
            r = idle; r.hs_req = 1'b1; r.hs_addr = 17'h00301;
            r.if_req = 1'b1; r.if_addr = 17'h00013;
            r.ls_req = (b < 4); r.ls_addr = 17'(32'h230 + b); r.ls_lock = (b < 3);
            drive(r);
        end

        // Random traffic; requests are held until the model grants them.
        r = idle; p_if = 0; p_ls = 0; p_hs = 0;
        for (int k = 0; k < 800; k++) begin
            r.rst = ($urandom_range(0, 149) != 0);
            if (!p_if && $urandom_range(0, 99) < 40) begin
                p_if = 1; r.if_addr = 17'($urandom_range(0, 1023));
            end
            if (!p_ls && $urandom_range(0, 99) < 45) begin
                p_ls = 1; r.ls_addr = 17'($urandom_range(0, 1023));
                r.ls_we = ($urandom_range(0, 2) == 0); r.ls_lock = ($urandom_range(0, 2) == 0);
                r.ls_wdata = 8'($urandom);
            end
            if (!p_hs && $urandom_range(0, 99) < 15) begin
                p_hs = 1; r.hs_addr = 17'($urandom_range(0, 1023));
                r.hs_we = ($urandom_range(0, 1) == 0); r.hs_wdata = 8'($urandom);
            end
            r.if_req = p_if; r.ls_req = p_ls; r.hs_req = p_hs;
            drive(r);
            if (!r.rst) begin
                p_if = 0; p_ls = 0; p_hs = 0;
            end else begin
                if (last_win == 1) p_if = 0;
                if (last_win == 2) p_ls = 0;
                if (last_win == 3) p_hs = 0;
            end
        end

        drive(idle); drive(idle); drive(idle);
        @(negedge clk); #1;
        checks++;
        if (expq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL drain got pending exp=%0d rd=%0d need 0/0", expq.size(), rdq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
